// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Fetch-stage program counter with stall, 2/4-byte stepping,
//            absolute jumps and a circular return-address stack.
// Revision : 1.0
// ============================================================================
module pc_unit #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR   = '0,
    parameter int              RAS_DEPTH      = 4,
    parameter int              INC_NORMAL     = 4,
    parameter int              INC_COMPRESSED = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           inc,
    input  logic                           compressed,
    input  logic                           load,
    input  logic [XLEN-1:0]                load_addr,
    input  logic                           call,
    input  logic [XLEN-1:0]                call_target,
    input  logic                           ret,
    output logic [XLEN-1:0]                pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int              CW       = $clog2(RAS_DEPTH + 1);
    localparam int              PW       = $clog2(RAS_DEPTH);
    localparam logic [XLEN-1:0] C_ALIGN  = ~XLEN'(1);
    localparam logic [CW-1:0]   C_DEPTH  = CW'(RAS_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_top;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic            r_unf;

    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_ret_addr;
    logic            w_active;
    logic            w_has_entry;
    logic            w_swap;
    logic            w_push;
    logic            w_wr_en;
    logic [PW-1:0]   w_wr_idx;

    assign w_step      = compressed ? XLEN'(INC_COMPRESSED) : XLEN'(INC_NORMAL);
    assign w_ret_addr  = r_pc + w_step;
    assign w_active    = !reset && !stall && !load;
    assign w_has_entry = (r_count != '0);
    // Tail call with a live entry rewrites the top in place; otherwise call pushes.
    assign w_swap      = call && ret && w_has_entry;
    assign w_push      = call && !w_swap;
    assign w_wr_en     = w_active && call;
    assign w_wr_idx    = w_swap ? r_top : r_top + PW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= RESET_VECTOR;
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                r_pc <= load_addr & C_ALIGN;
            end else if (w_swap) begin
                r_pc <= call_target & C_ALIGN;
            end else if (w_push) begin
                r_pc  <= call_target & C_ALIGN;
                r_top <= r_top + PW'(1);
                if (r_count == C_DEPTH) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else if (ret) begin
                if (w_has_entry) begin
                    r_pc    <= r_ras[r_top] & C_ALIGN;
                    r_top   <= r_top - PW'(1);
                    r_count <= r_count - CW'(1);
                end else begin
                    r_unf <= 1'b1;
                end
            end else if (inc) begin
                r_pc <= r_pc + w_step;
            end
        end
    end

    // Entry storage carries no reset; only the pointer and count define validity.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_ras[w_wr_idx] <= w_ret_addr;
        end
    end

    assign pc            = r_pc;
    assign ras_count     = r_count;
    assign ras_empty     = (r_count == '0);
    assign ras_full      = (r_count == C_DEPTH);
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Scoreboard bench for pc_unit against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_pc_unit;

    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset, stall, inc, compressed, load, call, ret;
    logic [31:0] load_addr, call_target;
    logic [31:0] pc;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow;

    always #5 clock = ~clock;

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH),
        .INC_NORMAL(4), .INC_COMPRESSED(2)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall), .inc(inc),
        .compressed(compressed), .load(load), .load_addr(load_addr),
        .call(call), .call_target(call_target), .ret(ret),
        .pc(pc), .ras_count(ras_count), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    typedef struct {
        logic [31:0] pc;
        int          count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: the RAS is a bounded list, newest at the back.
    task automatic model(input logic r, s, i, c, l, input logic [31:0] la,
                         input logic ca, input logic [31:0] ct, input logic rt);
        logic [31:0] step;
        step = c ? 32'd2 : 32'd4;
        if (r) begin
            m_pc = RV; m_ras.delete(); m_ovf = 0; m_unf = 0;
        end else if (s) begin
        end else if (l) begin
            m_pc = {la[31:1], 1'b0};
        end else if (ca && rt && m_ras.size() > 0) begin
            m_ras[m_ras.size()-1] = m_pc + step;
            m_pc = {ct[31:1], 1'b0};
        end else if (ca) begin
            m_ras.push_back(m_pc + step);
            if (m_ras.size() > DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1;
            end
            m_pc = {ct[31:1], 1'b0};
        end else if (rt) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back() & ~32'd1;
            else m_unf = 1;
        end else if (i) begin
            m_pc = m_pc + step;
        end
    endtask

    // One cycle of stimulus; spec_pc overrides the model pc when use_spec is set.
    task automatic drive(input logic r, s, i, c, l, input logic [31:0] la,
                         input logic ca, input logic [31:0] ct, input logic rt,
                         input logic use_spec = 0, input logic [31:0] spec_pc = 0);
        exp_t e;
        @(negedge clock);
        reset = r; stall = s; inc = i; compressed = c; load = l;
        load_addr = la; call = ca; call_target = ct; ret = rt;
        model(r, s, i, c, l, la, ca, ct, rt);
        e.pc    = use_spec ? spec_pc : m_pc;
        e.count = m_ras.size();
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, RV);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a new state after every edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",            pc,                   e.pc);
            chk("ras_count",     {29'd0, ras_count},   32'(e.count));
            chk("ras_empty",     {31'd0, ras_empty},   {31'd0, e.empty});
            chk("ras_full",      {31'd0, ras_full},    {31'd0, e.full});
            chk("ras_overflow",  {31'd0, ras_overflow},  {31'd0, e.ovf});
            chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, e.unf});
        end
    end

    initial begin
        reset = 1; stall = 0; inc = 0; compressed = 0; load = 0;
        load_addr = 0; call = 0; call_target = 0; ret = 0;
        m_pc = RV; m_ovf = 0; m_unf = 0;

        // Reset and sequential stepping
        do_reset();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h104);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h106);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h10A);

        // Load priority, alignment, wrap, stall
        drive(0, 0, 1, 0, 1, 32'hFFFF_FFFD, 0, 0, 0, 1, 32'hFFFF_FFFC);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0);
        drive(0, 1, 0, 0, 1, 32'h1234_5678, 1, 32'h40, 0, 1, 32'h0);

        // Nesting and underflow
        drive(0, 0, 0, 0, 1, 32'h200, 0, 0, 0, 1, 32'h200);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h400, 0, 1, 32'h400);
        drive(0, 0, 0, 1, 0, 0, 1, 32'h800, 0, 1, 32'h800);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h402);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h204);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h204);

        // Overflow: the oldest return (0x14) is discarded
        do_reset();
        drive(0, 0, 0, 0, 1, 32'h10, 0, 0, 0, 1, 32'h10);
        for (int k = 1; k <= 5; k++)
            drive(0, 0, 0, 0, 0, 0, 1, 32'h10 * (k + 1), 0, 1, 32'h10 * (k + 1));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h54);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h44);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h34);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h24);

        // Tail-call swap
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 1, 32'h300);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h500, 1, 1, 32'h500);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h304);

        // Reset while calling, then confirm nothing was pushed
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 0, 1, 32'h1000 + 32'(k * 16), 0);
        drive(1, 0, 0, 0, 0, 0, 1, 32'h2000, 0, 1, RV);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RV);

        // Randomised traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) == 0), $urandom(),
                  ($urandom_range(0, 3) == 0), $urandom(),
                  ($urandom_range(0, 3) == 0));
        end
        idle();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected states left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter sequencer; successor to the simple inc/load register.
- Adds:
  - synchronous reset to a configurable vector
  - stall
  - compressed (2-byte) or normal (4-byte) increment
  - absolute jump load
  - call/return support through an internal circular return-address stack (RAS) of configurable depth
- Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
- XLEN, 32, width of PC, addresses and RAS entries.
- RESET_VECTOR, 0, value loaded into pc on reset; bit 0 must be 0.
- RAS_DEPTH, 4, number of RAS entries; power of two, ≥2.
- INC_NORMAL, 4, increment for 32-bit instructions.
- INC_COMPRESSED, 2, increment when compressed=1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freeze all state this cycle.
- inc  in  1  advance pc sequentially.
- compressed  in  1  selects INC_COMPRESSED (1) or INC_NORMAL (0) for inc and for call return-address computation.
- load  in  1  absolute jump to load_addr.
- load_addr  in  XLEN  jump target.
- call  in  1  jump to call_target, push return address.
- call_target  in  XLEN  call destination.
- ret  in  1  jump to popped return address.
- pc  out  XLEN  current program counter (registered).
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- ras_empty  out  1  ras_count==0 (combinational from state).
- ras_full  out  1  ras_count==RAS_DEPTH.
- ras_overflow  out  1  sticky: a push discarded an entry.
- ras_underflow  out  1  sticky: a ret found RAS empty.

Behaviour:
- All state updates on posedge clock only. No combinational path from inputs to any output.
- Step size is S = compressed ? INC_COMPRESSED : INC_NORMAL.
- All additions are modulo 2^XLEN; wrap-around is silent.
- Targets have bit 0 forced to 0 when written to pc (load_addr, call_target, popped address).
- Priority per cycle: reset > stall > load > (call/ret) > inc > hold.
- reset:
  - pc ← RESET_VECTOR; ras_count ← 0; both sticky flags ← 0.
  - RAS pointer ← 0; entry contents are don't-care.
  - Reset overrides every other input, including in the middle of a call/ret sequence.
- stall: pc, RAS, count and flags all hold. Every other input is ignored.
- load: pc ← load_addr. RAS untouched, even if call/ret are also asserted.
- call only:
  - push (pc + S); pc ← call_target.
  - If the RAS is full: the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, ras_overflow ← 1.
- ret only:
  - If count > 0: pc ← top entry; pop; count−1.
  - If empty: pc holds, RAS unchanged, ras_underflow ← 1.
- call and ret together (tail-call swap):
  - pc ← call_target.
  - If count > 0: the top entry is replaced by (pc + S) and count is unchanged.
  - If empty: behaves as call only.
  - No flag changes except an overflow caused through the call-only path.
- inc: pc ← pc + S.
- No control asserted: pc holds.
- Latency: one cycle from control input to the new pc. ras_* outputs reflect post-edge state.
- Sticky flags clear only on reset.
- RAS storage: top pointer modulo RAS_DEPTH. A push increments the pointer then writes; a pop reads then decrements.

Test Plan:
1. Reset/inc:
   - Stimulus: RESET_VECTOR=0x100; reset 1 cycle; inc=1 for 3 cycles with compressed=0,1,0.
   - Required: pc = 0x100, 0x104, 0x106, 0x10A; ras_empty=1.
2. Wrap and priority:
   - Stimulus: load_addr=0xFFFFFFFD, load=1 and inc=1 in the same cycle; then inc alone.
   - Required: pc=0xFFFFFFFC, then 0x00000000.
   - Stimulus: next cycle, stall=1 with load=1.
   - Required: pc unchanged.
3. Call/ret nesting:
   - Stimulus: pc=0x200; call 0x400 (compressed=0); call 0x800 (compressed=1).
   - Required: pc=0x800, ras_count=2.
   - Stimulus: ret.
   - Required: pc=0x402.
   - Stimulus: ret.
   - Required: pc=0x204, ras_empty=1.
   - Stimulus: ret again.
   - Required: pc holds at 0x204, ras_underflow=1.
4. Overflow:
   - Stimulus: RAS_DEPTH=4; 5 calls from pc values 0x10, 0x20, 0x30, 0x40, 0x50 (S=4); then 4 rets.
   - Required after the calls: ras_full=1, ras_overflow=1, count=4.
   - Required from the rets: pc sequence 0x54, 0x44, 0x34, 0x24, then ras_empty=1.
5. Tail-call swap:
   - Stimulus: one call from 0x100 to 0x300; then call+ret at pc=0x300 with call_target=0x500.
   - Required: pc=0x500, count=1.
   - Stimulus: ret.
   - Required: pc=0x304.
6. Reset mid-operation:
   - Stimulus: 3 calls, then reset while call=1.
   - Required: pc=RESET_VECTOR, ras_count=0, flags=0, no push recorded.
